fb_bank_arbiter: RTL and testbench
==================================

Name: fb_bank_arbiter

Overview:
- Owns the single-port display frame-buffer RAM.
- Shares it between two requesters: the line shifter, which reads the front bank, and the host/UART loader, which writes the back bank.
- Double-buffers the RAM as two banks. Swaps them only at frame boundaries signalled by the row-scan controller, so a displayed frame never tears.

Parameters:
- ADDR_W, 11, word address width within one bank.
- DATA_W, 24, RAM word width (RGB pixel pair).
- MAX_WR_WAIT, 16, number of consecutive denied write cycles that forces a write slot (only with the optional feature).

Ports:
- clk_25MHz  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- rd_req  in  1  line-shifter read request.
- rd_addr  in  ADDR_W  read word address.
- rd_gnt  out  1  read granted this cycle.
- rd_valid  out  1  rd_data valid (one cycle after rd_gnt).
- rd_data  out  DATA_W  read data.
- wr_req  in  1  host write request; held until wr_ack.
- wr_addr  in  ADDR_W  write word address.
- wr_data  in  DATA_W  write data.
- wr_ack  out  1  write performed this cycle.
- swap_req  in  1  host pulse: swap banks at the next frame boundary.
- frame_start  in  1  scan-controller pulse: row 0 and PWM wrap, during blank.
- swap_pending  out  1  swap requested, not yet applied.
- front_bank  out  1  bank currently displayed.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W+1  {bank, word address}.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data; 1-cycle synchronous read latency.

Behaviour:
- Reset (async, rst=1), all outputs go to these values:
  - rd_gnt=0, rd_valid=0, wr_ack=0, ram_en=0, ram_we=0.
  - ram_addr=0, ram_wdata=0.
  - swap_pending=0, front_bank=0.
  - Starvation counter = 0.
  - Reset mid-access discards the access: no rd_valid, no wr_ack.
- Arbitration is combinational, one access per cycle:
  - Read has priority. rd_gnt = rd_req, unless a forced write slot is active.
  - Otherwise the write is served: wr_ack = wr_req.
  - Both requesters may hold their request every cycle; full throughput.
- Read path:
  - rd_gnt=1 drives ram_en=1, ram_we=0, ram_addr={front_bank, rd_addr}.
  - rd_valid is registered rd_gnt, one cycle later; rd_data = ram_rdata.
  - Fixed latency of 1 cycle from grant to data.
- Write path:
  - wr_ack=1 drives ram_en=1, ram_we=1, ram_addr={~front_bank, wr_addr}, ram_wdata=wr_data.
  - The host may change wr_addr/wr_data after the edge that ends the ack cycle.
- Idle (no grant): ram_en=0, ram_we=0, ram_addr and ram_wdata hold their last values.
- Swap FSM, states S_NORMAL and S_PENDING:
  - S_NORMAL: swap_req → S_PENDING, swap_pending=1.
  - S_PENDING: frame_start → front_bank toggles on that edge, swap_pending=0, → S_NORMAL.
  - S_PENDING: swap_req is ignored (no double swap).
  - swap_req and frame_start in the same cycle while in S_NORMAL: enter S_PENDING only; swap at the next frame_start.
  - frame_start in S_NORMAL: no effect.
  - A write acked in the cycle the swap is applied targets the old back bank, which becomes front.
  - A read granted in that cycle uses the old front bank. Its rd_valid data is still correct.
- Banks never change between frame_start pulses, so all reads of a frame come from one bank.

Optional Feature:
- Macro: FB_ARB_STARVE_GUARD_EN.
- Defined:
  - Counter increments each cycle wr_req=1 and wr_ack=0; clears on wr_ack or when wr_req=0.
  - When the counter reaches MAX_WR_WAIT, the next cycle is a forced write slot: rd_gnt=0 even if rd_req=1, and wr_ack=1. The counter then clears.
  - The line shifter must tolerate one stall cycle.
- Undefined: strict read priority; writes may starve indefinitely while rd_req stays high; no counter logic is instantiated.

Test Plan:
- Reset and idle:
  - Assert rst mid-read (rd_gnt=1) → rd_valid stays 0 next cycle.
  - All outputs are 0 and front_bank=0 while rst=1.
- Read latency:
  - RAM pre-loaded bank0[5]=0xABCDEF; rd_req=1, rd_addr=5 for 1 cycle → ram_addr=0x005 with rd_gnt=1.
  - Next cycle rd_valid=1, rd_data=0xABCDEF.
- Contention:
  - rd_req and wr_req both 1 for 3 cycles, then rd_req=0 → three reads granted, wr_ack=0.
  - Write acked on cycle 4, to ram_addr={1, wr_addr} with ram_we=1.
- Swap timing:
  - swap_req and frame_start in the same cycle → swap_pending=1, front_bank stays 0.
  - Next frame_start → front_bank=1, swap_pending=0.
  - A read of addr 7 now drives ram_addr=0x807.
- Duplicate swap:
  - Two swap_req pulses before frame_start → exactly one toggle at frame_start.
- Starvation (macro defined, MAX_WR_WAIT=16):
  - rd_req held high, wr_req high → wr_ack=1 and rd_gnt=0 on the 17th cycle.
  - Reads resume the following cycle.
  - Macro undefined: wr_ack stays 0 for 100 cycles.

Source files
------------

// File: rtl/fb_bank_arbiter_if.sv
// fb_bank_arbiter_if
//   Bundles the frame-buffer arbiter's request, handshake and RAM signals.
//   slave  : arbiter side (fb_bank_arbiter).
//   master : environment side (line shifter, host loader, scan controller, RAM).
//   Signals:
//     rd_req/rd_addr -> rd_gnt/rd_valid/rd_data      line-shifter read port
//     wr_req/wr_addr/wr_data -> wr_ack               host write port
//     swap_req/frame_start -> swap_pending/front_bank bank swap control
//     ram_en/ram_we/ram_addr/ram_wdata <- ram_rdata  single-port RAM port
interface fb_bank_arbiter_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 24
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;

  logic              swap_req;
  logic              frame_start;
  logic              swap_pending;
  logic              front_bank;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W:0]   ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
           swap_req, frame_start, ram_rdata,
    output rd_gnt, rd_valid, rd_data, wr_ack,
           swap_pending, front_bank,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data,
           swap_req, frame_start, ram_rdata,
    input  rd_gnt, rd_valid, rd_data, wr_ack,
           swap_pending, front_bank,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/fb_bank_arbiter.sv
// fb_bank_arbiter
//   Shares the single-port display frame-buffer RAM between the line shifter
//   (reads the front bank) and the host loader (writes the back bank). The RAM
//   is split into two banks by the address MSB; banks swap only on a
//   frame_start pulse after a swap_req, so a displayed frame never tears.
//   Reads have priority; one access per cycle; read data returns one cycle
//   after the grant.
// Optional feature (macro FB_ARB_STARVE_GUARD_EN): after MAX_WR_WAIT
//   consecutive denied write cycles, the next cycle is a forced write slot
//   that stalls the reader for one cycle.
// Ports:
//   clk_25MHz  system clock
//   rst        asynchronous active-high reset
//   bus        fb_bank_arbiter_if.slave (request, handshake and RAM signals)
module fb_bank_arbiter #(
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned MAX_WR_WAIT = 16
) (
  input  logic                   clk_25MHz,
  input  logic                   rst,
  fb_bank_arbiter_if.slave       bus
);

  if (MAX_WR_WAIT == 0) begin : g_bad_max_wr_wait
    $error("MAX_WR_WAIT must be at least 1");
  end

  typedef enum logic {
    S_NORMAL  = 1'b0,
    S_PENDING = 1'b1
  } swap_state_t;

  swap_state_t       r_state;
  swap_state_t       w_state_nxt;
  logic              w_toggle;
  logic              r_front;

  logic              w_force;
  logic              w_rd_gnt;
  logic              w_wr_ack;
  logic              w_ram_en;
  logic [ADDR_W:0]   w_addr_sel;
  logic [ADDR_W:0]   r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_rd_valid;

  // ---------------------------------------------------------------------------
  // Swap FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      r_state <= S_NORMAL;
      r_front <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_toggle) begin
        r_front <= ~r_front;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_toggle    = 1'b0;
    case (r_state)
      // frame_start is ignored here, so a same-cycle swap_req only arms the
      // swap for the following frame boundary.
      S_NORMAL: begin
        if (bus.swap_req) begin
          w_state_nxt = S_PENDING;
        end
      end
      S_PENDING: begin
        if (bus.frame_start) begin
          w_state_nxt = S_NORMAL;
          w_toggle    = 1'b1;
        end
      end
      default: w_state_nxt = S_NORMAL;
    endcase
  end

  assign bus.swap_pending = (r_state == S_PENDING);
  assign bus.front_bank   = r_front;

  // ---------------------------------------------------------------------------
  // Write starvation guard
  // ---------------------------------------------------------------------------
`ifdef FB_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(MAX_WR_WAIT + 1);

  logic [CNT_W-1:0] r_starve_cnt;

  // The counter never passes MAX_WR_WAIT: reaching it forces the ack that
  // clears it.
  assign w_force = bus.wr_req && (r_starve_cnt == CNT_W'(MAX_WR_WAIT));

  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (!bus.wr_req || w_wr_ack) begin
      r_starve_cnt <= '0;
    end else begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end
`else
  assign w_force = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration and RAM port
  // ---------------------------------------------------------------------------
  // Grants are masked while rst is high so every output reads zero in reset.
  assign w_rd_gnt = !rst && bus.rd_req && !w_force;
  assign w_wr_ack = !rst && bus.wr_req && !w_rd_gnt;
  assign w_ram_en = w_rd_gnt || w_wr_ack;

  // Both paths use the pre-swap bank value, so an access in the swap cycle
  // hits the bank that was current when it was granted.
  assign w_addr_sel = w_rd_gnt ? {r_front, bus.rd_addr} : {~r_front, bus.wr_addr};

  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_gnt;
      if (w_ram_en) begin
        r_ram_addr <= w_addr_sel;
      end
      if (w_wr_ack) begin
        r_ram_wdata <= bus.wr_data;
      end
    end
  end

  // Address/data present the live request when granted and hold the last
  // value when idle.
  assign bus.ram_en    = w_ram_en;
  assign bus.ram_we    = w_wr_ack;
  assign bus.ram_addr  = w_ram_en ? w_addr_sel : r_ram_addr;
  assign bus.ram_wdata = w_wr_ack ? bus.wr_data : r_ram_wdata;

  assign bus.rd_gnt   = w_rd_gnt;
  assign bus.wr_ack   = w_wr_ack;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = bus.ram_rdata;

endmodule

// File: tb/tb_fb_bank_arbiter.sv
// tb_fb_bank_arbiter
//   Directed bench for fb_bank_arbiter: reset, read latency, contention,
//   swap timing, duplicate swap and write starvation. Includes a behavioural
//   single-port RAM with one-cycle read latency.
module tb_fb_bank_arbiter;
  localparam int unsigned ADDR_W      = 11;
  localparam int unsigned DATA_W      = 24;
  localparam int unsigned MAX_WR_WAIT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  fb_bank_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fb_bank_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .MAX_WR_WAIT (MAX_WR_WAIT)
  ) dut (
    .clk_25MHz (clk),
    .rst       (rst),
    .bus       (bus.slave)
  );

  always #20 clk = ~clk;

  logic [DATA_W-1:0] mem [0:(1 << (ADDR_W + 1)) - 1];

  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata     <= mem[bus.ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < (1 << (ADDR_W + 1)); i++) mem[i] = '0;
    mem[5] = 24'hABCDEF;
    bus.ram_rdata   = '0;
    bus.rd_req      = 1'b0;
    bus.rd_addr     = '0;
    bus.wr_req      = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.swap_req    = 1'b0;
    bus.frame_start = 1'b0;

    // Reset: outputs at zero even with a read request present
    tick();
    tick();
    bus.rd_req = 1'b1;
    mid();
    chk("rst_rd_gnt",   bus.rd_gnt,       0);
    chk("rst_rd_valid", bus.rd_valid,     0);
    chk("rst_wr_ack",   bus.wr_ack,       0);
    chk("rst_ram_en",   bus.ram_en,       0);
    chk("rst_ram_we",   bus.ram_we,       0);
    chk("rst_ram_addr", bus.ram_addr,     0);
    chk("rst_wdata",    bus.ram_wdata,    0);
    chk("rst_pending",  bus.swap_pending, 0);
    chk("rst_front",    bus.front_bank,   0);
    tick();
    rst = 1'b0;
    bus.rd_req = 1'b0;

    // Reset asserted mid-read discards the read
    bus.rd_req  = 1'b1;
    bus.rd_addr = 11'd3;
    mid();
    chk("midrd_gnt", bus.rd_gnt, 1);
    #5 rst = 1'b1;
    tick();
    chk("midrd_valid", bus.rd_valid, 0);
    bus.rd_req = 1'b0;
    rst = 1'b0;
    tick();

    // Read latency
    bus.rd_req  = 1'b1;
    bus.rd_addr = 11'd5;
    mid();
    chk("rd_gnt",      bus.rd_gnt,   1);
    chk("rd_ram_en",   bus.ram_en,   1);
    chk("rd_ram_we",   bus.ram_we,   0);
    chk("rd_ram_addr", bus.ram_addr, 32'h005);
    tick();
    bus.rd_req = 1'b0;
    chk("rd_valid",    bus.rd_valid, 1);
    chk("rd_data",     bus.rd_data,  32'hABCDEF);
    mid();
    chk("idle_ram_en",   bus.ram_en,   0);
    chk("idle_ram_addr", bus.ram_addr, 32'h005);
    tick();
    chk("rd_valid_drop", bus.rd_valid, 0);

    // Contention: read wins three cycles, then the write goes to bank 1
    bus.rd_req  = 1'b1;
    bus.rd_addr = 11'd1;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 11'h010;
    bus.wr_data = 24'h123456;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("cont_rd_gnt", bus.rd_gnt, 1);
      chk("cont_wr_ack", bus.wr_ack, 0);
      tick();
    end
    bus.rd_req = 1'b0;
    mid();
    chk("cont_wr_ack4", bus.wr_ack,    1);
    chk("cont_rd_gnt4", bus.rd_gnt,    0);
    chk("cont_ram_we",  bus.ram_we,    1);
    chk("cont_addr",    bus.ram_addr,  32'h810);
    chk("cont_wdata",   bus.ram_wdata, 32'h123456);
    tick();
    bus.wr_req  = 1'b0;
    bus.wr_data = '0;
    mid();
    chk("hold_wdata",  bus.ram_wdata, 32'h123456);
    chk("hold_ram_en", bus.ram_en,    0);
    tick();

    // Swap: swap_req with frame_start only arms the swap
    bus.swap_req    = 1'b1;
    bus.frame_start = 1'b1;
    tick();
    bus.swap_req    = 1'b0;
    bus.frame_start = 1'b0;
    chk("sw_pending", bus.swap_pending, 1);
    chk("sw_front0",  bus.front_bank,   0);
    tick();
    chk("sw_front_hold", bus.front_bank, 0);
    // Write in the swap cycle lands in the old back bank (bank 1)
    bus.frame_start = 1'b1;
    bus.wr_req      = 1'b1;
    bus.wr_addr     = 11'h020;
    bus.wr_data     = 24'h0F0F0F;
    mid();
    chk("sw_wr_ack",  bus.wr_ack,   1);
    chk("sw_wr_addr", bus.ram_addr, 32'h820);
    tick();
    bus.frame_start = 1'b0;
    bus.wr_req      = 1'b0;
    chk("sw_front1",   bus.front_bank,   1);
    chk("sw_pending0", bus.swap_pending, 0);
    // Reads now come from bank 1
    bus.rd_req  = 1'b1;
    bus.rd_addr = 11'd7;
    mid();
    chk("sw_rd_addr", bus.ram_addr, 32'h807);
    tick();
    bus.rd_addr = 11'h010;
    tick();
    bus.rd_addr = 11'h020;
    chk("sw_rd_data10", bus.rd_data, 32'h123456);
    tick();
    bus.rd_req = 1'b0;
    chk("sw_rd_data20", bus.rd_data, 32'h0F0F0F);
    tick();

    // Duplicate swap: two requests, one toggle
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    tick();
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    chk("dup_pending", bus.swap_pending, 1);
    chk("dup_front1",  bus.front_bank,   1);
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    chk("dup_front0",   bus.front_bank,   0);
    chk("dup_pending0", bus.swap_pending, 0);
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    chk("fs_normal_front", bus.front_bank,   0);
    chk("fs_normal_pend",  bus.swap_pending, 0);

    // Starvation
    bus.rd_req  = 1'b1;
    bus.rd_addr = 11'd2;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 11'h030;
    bus.wr_data = 24'h55AA55;
`ifdef FB_ARB_STARVE_GUARD_EN
    for (int c = 1; c <= 18; c++) begin
      mid();
      chk("starve_rd_gnt", bus.rd_gnt, (c == 17) ? 32'd0 : 32'd1);
      chk("starve_wr_ack", bus.wr_ack, (c == 17) ? 32'd1 : 32'd0);
      if (c == 17) chk("starve_addr", bus.ram_addr, 32'h830);
      tick();
    end
`else
    for (int c = 1; c <= 100; c++) begin
      mid();
      chk("nostarve_wr_ack", bus.wr_ack, 0);
      tick();
    end
`endif
    bus.rd_req = 1'b0;
    mid();
    chk("starve_release_ack", bus.wr_ack, 1);
    tick();
    bus.wr_req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
